// File: rtl/scp_monitor.sv
// Multi-channel status monitor: escalating WARN/ALERT/LOCKDOWN dwell FSM with
// registered channel counts and a channel-0 R,Y,G,R override sequence.
module scp_monitor #(
    parameter  int CH    = 4,
    parameter  int TW    = 6,
    parameter  int T_YEL = 20,
    parameter  int T_RED = 10,
    localparam int CW    = $clog2(CH + 1)
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic [CH-1:0] green,
    input  logic [CH-1:0] yellow,
    input  logic [CH-1:0] red,
    output logic [2:0]    state,
    output logic [TW-1:0] timer,
    output logic          a1,
    output logic          a2,
    output logic          a3,
    output logic          cheat_out,
    output logic [CW-1:0] n_yel,
    output logic [CW-1:0] n_red
);

    typedef enum logic [2:0] {
        ALLOK    = 3'd0,
        WARN     = 3'd1,
        ALERT    = 3'd2,
        LOCKDOWN = 3'd3
    } state_t;

    function automatic logic [CW-1:0] popcount(input logic [CH-1:0] v);
        logic [CW-1:0] s;
        s = '0;
        for (int i = 0; i < CH; i++) begin
            s = s + CW'(v[i]);
        end
        return s;
    endfunction

    logic [CH-1:0] grn_s, yel_s, red_s;
    logic          any_red_s, any_yel_s, all_grn_s;
    logic          c0_red_s, c0_yel_s, c0_grn_s;
    logic [1:0]    match_r, match_next_s;
    logic          hit_s;
    state_t        state_r, state_next_s;
    logic [TW-1:0] timer_r, timer_next_s;
    logic          a1_r, a2_r, a3_r, cheat_r;
    logic [CW-1:0] n_yel_r, n_red_r;

    // Per-channel classification; anything other than exactly one colour is a fault (red).
    always_comb begin
        grn_s = '0;
        yel_s = '0;
        red_s = '0;
        for (int i = 0; i < CH; i++) begin
            grn_s[i] = green[i] & ~yellow[i] & ~red[i];
            yel_s[i] = yellow[i] & ~green[i] & ~red[i];
            red_s[i] = ~(grn_s[i] | yel_s[i]);
        end
    end

    assign any_red_s = |red_s;
    assign any_yel_s = |yel_s;
    assign all_grn_s = &grn_s;
    assign c0_red_s  = red[0] & ~green[0] & ~yellow[0];
    assign c0_yel_s  = yellow[0] & ~green[0] & ~red[0];
    assign c0_grn_s  = green[0] & ~yellow[0] & ~red[0];

    // Override matcher: match_r counts steps of R,Y,G,R seen; a breaking red restarts at step 1.
    always_comb begin
        match_next_s = 2'd0;
        hit_s        = 1'b0;
        case (match_r)
            2'd0: begin
                if (c0_red_s) match_next_s = 2'd1;
                else          match_next_s = 2'd0;
            end
            2'd1: begin
                if (c0_yel_s)      match_next_s = 2'd2;
                else if (c0_red_s) match_next_s = 2'd1;
                else               match_next_s = 2'd0;
            end
            2'd2: begin
                if (c0_grn_s)      match_next_s = 2'd3;
                else if (c0_red_s) match_next_s = 2'd1;
                else               match_next_s = 2'd0;
            end
            2'd3: begin
                if (c0_red_s) hit_s = 1'b1;
                else          hit_s = 1'b0;
                match_next_s = 2'd0;
            end
            default: begin
                match_next_s = 2'd0;
                hit_s        = 1'b0;
            end
        endcase
    end

    // Next-state and dwell timer; the override wins over every escalation.
    always_comb begin
        state_next_s = state_r;
        timer_next_s = timer_r;
        if (hit_s) begin
            state_next_s = ALLOK;
            timer_next_s = '0;
        end else begin
            case (state_r)
                ALLOK: begin
                    if (any_red_s) begin
                        state_next_s = ALERT;
                        timer_next_s = TW'(T_RED);
                    end else if (any_yel_s) begin
                        state_next_s = WARN;
                        timer_next_s = TW'(T_YEL);
                    end else begin
                        state_next_s = ALLOK;
                        timer_next_s = '0;
                    end
                end
                WARN: begin
                    if (any_red_s) begin
                        state_next_s = ALERT;
                        timer_next_s = TW'(T_RED);
                    end else if (all_grn_s) begin
                        state_next_s = ALLOK;
                        timer_next_s = '0;
                    end else if (timer_r <= TW'(1)) begin
                        state_next_s = ALERT;
                        timer_next_s = TW'(T_RED);
                    end else begin
                        state_next_s = WARN;
                        timer_next_s = timer_r - TW'(1);
                    end
                end
                ALERT: begin
                    if (all_grn_s) begin
                        state_next_s = ALLOK;
                        timer_next_s = '0;
                    end else if (timer_r <= TW'(1)) begin
                        state_next_s = LOCKDOWN;
                        timer_next_s = '0;
                    end else begin
                        state_next_s = ALERT;
                        timer_next_s = timer_r - TW'(1);
                    end
                end
                LOCKDOWN: begin
                    state_next_s = LOCKDOWN;
                    timer_next_s = '0;
                end
                default: begin
                    state_next_s = ALLOK;
                    timer_next_s = '0;
                end
            endcase
        end
    end

    // State, timer, action lines, override pulse and counts all register together.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_r <= ALLOK;
            timer_r <= '0;
            match_r <= 2'd0;
            a1_r    <= 1'b0;
            a2_r    <= 1'b0;
            a3_r    <= 1'b0;
            cheat_r <= 1'b0;
            n_yel_r <= '0;
            n_red_r <= '0;
        end else begin
            state_r <= state_next_s;
            timer_r <= timer_next_s;
            match_r <= match_next_s;
            a1_r    <= (state_next_s == WARN);
            a2_r    <= (state_next_s == ALERT);
            a3_r    <= (state_next_s == LOCKDOWN);
            cheat_r <= hit_s;
            n_yel_r <= popcount(yel_s);
            n_red_r <= popcount(red_s);
        end
    end

    assign state     = state_r;
    assign timer     = timer_r;
    assign a1        = a1_r;
    assign a2        = a2_r;
    assign a3        = a3_r;
    assign cheat_out = cheat_r;
    assign n_yel     = n_yel_r;
    assign n_red     = n_red_r;

endmodule

// File: tb/tb_scp_monitor.sv
// Directed and randomized bench for scp_monitor (CH=4, TW=6, T_YEL=20, T_RED=10)
// against a rule-level reference model.
module tb_scp_monitor;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic [3:0] green = 4'h0, yellow = 4'h0, red = 4'h0;
    logic [2:0] state;
    logic [5:0] timer;
    logic       a1, a2, a3, cheat_out;
    logic [2:0] n_yel, n_red;

    int passed = 0;
    int total  = 0;

    // model state
    int m_state = 0, m_timer = 0, m_cheat = 0, m_ny = 0, m_nr = 0;
    int hist[$];

    scp_monitor #(.CH(4), .TW(6), .T_YEL(20), .T_RED(10)) dut (
        .clock(clock), .reset_n(reset_n),
        .green(green), .yellow(yellow), .red(red),
        .state(state), .timer(timer),
        .a1(a1), .a2(a2), .a3(a3), .cheat_out(cheat_out),
        .n_yel(n_yel), .n_red(n_red)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input int obs, input int exp);
        total = total + 1;
        assert (obs === exp) begin
            passed = passed + 1;
        end else begin
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // colour code: 1=red, 2=yellow, 3=green, 0=fault
    function automatic int colour(input logic g, input logic y, input logic r);
        case ({g, y, r})
            3'b100:  return 3;
            3'b010:  return 2;
            3'b001:  return 1;
            default: return 0;
        endcase
    endfunction

    task automatic model_update(input logic [3:0] g, y, r, input logic rn);
        int ny, nr, ng, n;
        bit hit;
        if (!rn) begin
            m_state = 0; m_timer = 0; m_cheat = 0; m_ny = 0; m_nr = 0;
            hist.delete();
            return;
        end
        ny = 0; nr = 0; ng = 0;
        for (int i = 0; i < 4; i++) begin
            case (colour(g[i], y[i], r[i]))
                3:       ng++;
                2:       ny++;
                default: nr++;
            endcase
        end
        m_ny = ny;
        m_nr = nr;
        hist.push_back(colour(g[0], y[0], r[0]));
        if (hist.size() > 4) void'(hist.pop_front());
        n = hist.size();
        hit = (n == 4) && hist[0] == 1 && hist[1] == 2 && hist[2] == 3 && hist[3] == 1;
        if (hit) hist.delete();
        m_cheat = hit ? 1 : 0;
        if (hit) begin
            m_state = 0; m_timer = 0;
        end else if (m_state == 0) begin
            if (nr > 0)      begin m_state = 2; m_timer = 10; end
            else if (ny > 0) begin m_state = 1; m_timer = 20; end
            else             m_timer = 0;
        end else if (m_state == 1) begin
            if (nr > 0)            begin m_state = 2; m_timer = 10; end
            else if (ng == 4)      begin m_state = 0; m_timer = 0; end
            else if (m_timer == 1) begin m_state = 2; m_timer = 10; end
            else                   m_timer = m_timer - 1;
        end else if (m_state == 2) begin
            if (ng == 4)           begin m_state = 0; m_timer = 0; end
            else if (m_timer == 1) begin m_state = 3; m_timer = 0; end
            else                   m_timer = m_timer - 1;
        end else begin
            m_timer = 0;
        end
    endtask

    task automatic step(input logic [3:0] g, y, r, input logic rn);
        green = g; yellow = y; red = r; reset_n = rn;
        @(posedge clock);
        model_update(g, y, r, rn);
        #1;
        chk("state", int'(state), m_state);
        chk("timer", int'(timer), m_timer);
        chk("a1", int'(a1), (m_state == 1) ? 1 : 0);
        chk("a2", int'(a2), (m_state == 2) ? 1 : 0);
        chk("a3", int'(a3), (m_state == 3) ? 1 : 0);
        chk("cheat_out", int'(cheat_out), m_cheat);
        chk("n_yel", int'(n_yel), m_ny);
        chk("n_red", int'(n_red), m_nr);
    endtask

    task automatic all_green();
        step(4'b1111, 4'b0000, 4'b0000, 1'b1);
    endtask

    task automatic do_reset();
        step(4'b1111, 4'b0000, 4'b0000, 1'b0);
    endtask

    // channel 0 driven with c (1=R,2=Y,3=G), others green
    task automatic ch0(input int c);
        case (c)
            1:       step(4'b1110, 4'b0000, 4'b0001, 1'b1);
            2:       step(4'b1110, 4'b0001, 4'b0000, 1'b1);
            default: step(4'b1111, 4'b0000, 4'b0000, 1'b1);
        endcase
    endtask

    function automatic logic [2:0] rand_chan();
        int k;
        k = $urandom_range(0, 9);
        if (k <= 5)      return 3'b100;
        else if (k <= 7) return 3'b010;
        else if (k == 8) return 3'b001;
        else             return 3'($urandom_range(0, 7));
    endfunction

    initial begin
        logic [2:0] c;
        logic [3:0] g, y, r;

        do_reset();
        do_reset();
        chk("reset_state", int'(state), 0);

        for (int i = 0; i < 50; i++) all_green();
        chk("green50_state", int'(state), 0);

        // channel 2 held yellow: WARN -> ALERT -> LOCKDOWN
        step(4'b1011, 4'b0100, 4'b0000, 1'b1);
        chk("y_warn_state", int'(state), 1);
        chk("y_warn_timer", int'(timer), 20);
        for (int i = 0; i < 19; i++) step(4'b1011, 4'b0100, 4'b0000, 1'b1);
        chk("y_warn_last", int'(timer), 1);
        step(4'b1011, 4'b0100, 4'b0000, 1'b1);
        chk("y_alert_state", int'(state), 2);
        chk("y_alert_timer", int'(timer), 10);
        for (int i = 0; i < 9; i++) step(4'b1011, 4'b0100, 4'b0000, 1'b1);
        step(4'b1011, 4'b0100, 4'b0000, 1'b1);
        chk("y_lock_state", int'(state), 3);
        chk("y_lock_a3", int'(a3), 1);
        for (int i = 0; i < 5; i++) all_green();
        chk("lock_sticky", int'(state), 3);

        // red preempts WARN countdown
        do_reset();
        for (int i = 0; i < 5; i++) step(4'b1101, 4'b0010, 4'b0000, 1'b1);
        chk("pre_timer16", int'(timer), 16);
        step(4'b0111, 4'b0000, 4'b1000, 1'b1);
        chk("pre_alert", int'(state), 2);
        chk("pre_timer10", int'(timer), 10);
        all_green();
        chk("pre_allok", int'(state), 0);

        // fault on channel 0
        step(4'b1111, 4'b0000, 4'b0001, 1'b1);
        chk("fault_alert", int'(state), 2);
        chk("fault_nred", int'(n_red), 1);
        all_green();
        chk("fault_clear", int'(state), 0);

        // override from LOCKDOWN, then a broken pattern
        for (int i = 0; i < 11; i++) step(4'b1101, 4'b0000, 4'b0010, 1'b1);
        chk("lock2_state", int'(state), 3);
        ch0(1); ch0(2); ch0(3); ch0(1);
        chk("cheat_pulse", int'(cheat_out), 1);
        chk("cheat_state", int'(state), 0);
        all_green();
        chk("cheat_one_cycle", int'(cheat_out), 0);
        ch0(1); ch0(2); ch0(2); ch0(3); ch0(1);
        chk("nocheat_ryygr", int'(cheat_out), 0);

        // reset mid-ALERT and reset clearing a partial override
        do_reset();
        for (int i = 0; i < 6; i++) step(4'b1101, 4'b0000, 4'b0010, 1'b1);
        chk("alert_t5", int'(timer), 5);
        do_reset();
        chk("rst_alert_state", int'(state), 0);
        ch0(1); ch0(2);
        do_reset();
        ch0(3); ch0(1);
        chk("rst_cheat_clear", int'(cheat_out), 0);

        // randomized traffic with occasional resets and injected overrides
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 59) == 0) begin
                ch0(1); ch0(2); ch0(3); ch0(1);
            end else if ($urandom_range(0, 3) == 0) begin
                all_green();
            end else begin
                for (int i = 0; i < 4; i++) begin
                    c = rand_chan();
                    g[i] = c[2]; y[i] = c[1]; r[i] = c[0];
                end
                step(g, y, r, ($urandom_range(0, 99) != 0));
            end
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/scp_monitor.md
SCP_MONITOR -- requirements
Module: scp_monitor

Interface
REQ-001 SHALL have parameter CH, default 4, number of monitored channels (1..8).
REQ-002 SHALL have parameter TW, default 6, timer width in bits.
REQ-003 SHALL have parameter T_YEL, default 20, WARN dwell in cycles (1..2^TW-1).
REQ-004 SHALL have parameter T_RED, default 10, ALERT dwell in cycles (1..2^TW-1).
REQ-005 SHALL have port clock, input, 1, single rising-edge clock.
REQ-006 SHALL have port reset_n, input, 1, synchronous active-low reset.
REQ-007 SHALL have ports green / yellow / red, input, CH each, per-channel status lines.
REQ-008 SHALL have port state, output, 3, current FSM state.
REQ-009 SHALL have port timer, output, TW, dwell countdown.
REQ-010 SHALL have ports a1 / a2 / a3, output, 1 each, action lines.
REQ-011 SHALL have port cheat_out, output, 1, override pulse.
REQ-012 SHALL have ports n_yel / n_red, output, CW = $clog2(CH+1) each, registered channel counts.

Function
REQ-013 Channel i SHALL be classified each cycle: exactly one of green/yellow/red high -> that colour; any other combination (none, several) -> fault, counted as red.
REQ-014 n_yel and n_red SHALL be registered counts of yellow and red/fault channels, one cycle after input sampling.
REQ-015 State encoding SHALL be ALLOK=0, WARN=1, ALERT=2, LOCKDOWN=3; codes 4..7 SHALL never be output.
REQ-016 FSM decisions SHALL use the current-cycle classification, not the registered counts.
REQ-017 ALLOK: any red -> ALERT, timer<=T_RED; else any yellow -> WARN, timer<=T_YEL; else stay, timer<=0.
REQ-018 WARN: any red -> ALERT, timer<=T_RED; else all green -> ALLOK, timer<=0; else timer==1 -> ALERT, timer<=T_RED; else timer<=timer-1.
REQ-019 ALERT: all green -> ALLOK, timer<=0; else timer==1 -> LOCKDOWN, timer<=0; else timer<=timer-1.
REQ-020 In ALERT, yellow-only inputs SHALL keep counting down and SHALL NOT fall back to WARN.
REQ-021 LOCKDOWN SHALL be sticky, with timer held at 0, regardless of inputs; only reset or cheat leaves it.
REQ-022 A new red in WARN SHALL preempt the WARN timer immediately: reload T_RED, no carry-over.
REQ-023 The timer SHALL never wrap below 0.
REQ-024 Cheat detector SHALL watch channel 0 only.
REQ-025 Cheat pattern SHALL be pure red, yellow, green, red on four consecutive cycles; any other channel-0 value restarts the match.
REQ-026 A red that breaks the pattern SHALL count as step 1 of a new match.
REQ-027 On the cycle after the fourth step is sampled, cheat_out SHALL be 1 for exactly one cycle, state SHALL be ALLOK and timer 0, from any state including LOCKDOWN.
REQ-028 Cheat SHALL have priority over every transition in REQ-017..REQ-021.
REQ-029 The final red of a cheat SHALL NOT trigger ALERT on that edge.
REQ-030 The matcher SHALL clear after a hit; overlapping matches are not supported.
REQ-031 a1 SHALL be (state==WARN), a2 (state==ALERT), a3 (state==LOCKDOWN); all are registered with state, at most one high.
REQ-032 Outputs SHALL change only on rising clock edges.

Reset
REQ-033 When reset_n is low at a rising edge, outputs SHALL become state=ALLOK, timer=0, a1=a2=a3=0, cheat_out=0, n_yel=n_red=0, and the cheat matcher SHALL clear.
REQ-034 Reset SHALL take priority over cheat and all transitions, including mid-countdown and in LOCKDOWN.
REQ-035 Normal evaluation SHALL resume on the first edge with reset_n high, using that cycle's inputs.

Verification (CH=4, TW=6, T_YEL=20, T_RED=10)
REQ-036 All channels green for 50 cycles after reset -> state=0, timer=0, a1..a3=0, n_yel=n_red=0 throughout.
REQ-037 Channel 2 held yellow -> WARN with timer 20, counts to 1, then ALERT with timer 10 (a2=1), counts to 1, then LOCKDOWN (a3=1, timer 0); later all green -> state remains 3.
REQ-038 Channel 1 yellow for 5 cycles, then channel 3 red -> WARN timer 16 at preemption edge, then ALERT timer 10; then all green -> ALLOK next edge.
REQ-039 Channel 0 green=red=1 (fault) -> ALERT, n_red=1; restore green -> ALLOK.
REQ-040 In LOCKDOWN, drive channel 0 R,Y,G,R -> cheat_out=1 for one cycle, state=0, timer=0; pattern R,Y,Y,G,R -> no cheat_out.
REQ-041 reset_n low for one edge during ALERT with timer=5 -> next state=0, timer=0; cheat prefix R,Y then reset -> G,R afterwards gives no cheat_out.
